// File: rtl/multi_lamp_ctrl_if.sv
// Switch/force inputs and lamp/status outputs of the multi-channel lamp controller.
interface multi_lamp_ctrl_if #(
  parameter int N_CH = 2,
  parameter int N_SW = 3
) ();
  logic [N_CH*N_SW-1:0] sw;
  logic [N_CH-1:0]      force_on;
  logic [N_CH-1:0]      force_off;
  logic [N_CH-1:0]      lamp;
  logic [N_CH-1:0]      active;
  logic [N_CH-1:0]      warn;

  modport master (output sw, force_on, force_off, input lamp, active, warn);
  modport slave  (input sw, force_on, force_off, output lamp, active, warn);
endinterface

// File: rtl/multi_lamp_ctrl.sv
// Per-channel retriggerable lamp hold timer; switch toggle reaches lamp/active/warn 4 edges later, forces 1 edge.
// No backpressure. Optional WARN blink on tmr[BLINK_SHIFT] when LAMP_WARN_BLINK_EN is defined.
module multi_lamp_ctrl #(
  parameter int N_CH        = 2,
  parameter int N_SW        = 3,
  parameter int HOLD_CYCLES = 2**28 - 1,
  parameter int WARN_CYCLES = 2**24,
  parameter int BLINK_SHIFT = 22
) (
  input  logic               clk,
  input  logic               rst,
  multi_lamp_ctrl_if.slave   bus
);
  localparam int TW = $clog2(HOLD_CYCLES);

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("multi_lamp_ctrl: HOLD_CYCLES must be at least 2");
  end
  if (WARN_CYCLES >= HOLD_CYCLES) begin : g_bad_warn
    $error("multi_lamp_ctrl: WARN_CYCLES must be below HOLD_CYCLES");
  end
  if (BLINK_SHIFT >= TW) begin : g_bad_blink
    $error("multi_lamp_ctrl: BLINK_SHIFT must index a timer bit");
  end

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_WARN = 2'd2
  } state_t;

  logic [N_CH*N_SW-1:0] s1, s2;
  logic [N_CH-1:0]      p_q, par, trig, blink;
  logic [N_CH-1:0]      lamp_q, active_q, warn_q;
  logic [N_CH-1:0]      lamp_d, active_d, warn_d;
  state_t               state_q [N_CH];
  state_t               state_d [N_CH];
  logic [TW-1:0]        tmr_q   [N_CH];
  logic [TW-1:0]        tmr_d   [N_CH];

  always_comb begin
    par      = '0;
    trig     = '0;
    blink    = '0;
    lamp_d   = '0;
    active_d = '0;
    warn_d   = '0;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      tmr_d[c]   = tmr_q[c];
      // parity makes any single toggle in the group a trigger; simultaneous pairs cancel
      par[c]  = ^s2[c*N_SW +: N_SW];
      trig[c] = par[c] ^ p_q[c];

      if (bus.force_off[c]) begin
        state_d[c] = ST_OFF;
        tmr_d[c]   = '0;
      end else if (trig[c]) begin
        tmr_d[c]   = TW'(HOLD_CYCLES - 1);
        state_d[c] = (HOLD_CYCLES - 1 < WARN_CYCLES) ? ST_WARN : ST_ON;
      end else begin
        case (state_q[c])
          ST_ON: begin
            if (tmr_q[c] != '0) tmr_d[c] = tmr_q[c] - TW'(1);
            // with no warning window the hold ends directly from ON
            if (tmr_q[c] == TW'(WARN_CYCLES))
              state_d[c] = (WARN_CYCLES == 0) ? ST_OFF : ST_WARN;
          end
          ST_WARN: begin
            if (tmr_q[c] == '0) state_d[c] = ST_OFF;
            else                tmr_d[c]   = tmr_q[c] - TW'(1);
          end
          default: begin
            state_d[c] = ST_OFF;
            tmr_d[c]   = '0;
          end
        endcase
      end

`ifdef LAMP_WARN_BLINK_EN
      blink[c] = tmr_q[c][BLINK_SHIFT];
`else
      blink[c] = 1'b1;
`endif

      if (bus.force_off[c])            lamp_d[c] = 1'b0;
      else if (bus.force_on[c])        lamp_d[c] = 1'b1;
      else if (state_q[c] == ST_ON)    lamp_d[c] = 1'b1;
      else if (state_q[c] == ST_WARN)  lamp_d[c] = blink[c];
      else                             lamp_d[c] = 1'b0;

      active_d[c] = (state_q[c] != ST_OFF);
      warn_d[c]   = (state_q[c] == ST_WARN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      p_q      <= '0;
      lamp_q   <= '0;
      active_q <= '0;
      warn_q   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= ST_OFF;
        tmr_q[c]   <= '0;
      end
    end else begin
      s1       <= bus.sw;
      s2       <= s1;
      // keeps tracking under force_off so its release cannot fire a stale trigger
      p_q      <= par;
      lamp_q   <= lamp_d;
      active_q <= active_d;
      warn_q   <= warn_d;
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        tmr_q[c]   <= tmr_d[c];
      end
    end
  end

  assign bus.lamp   = lamp_q;
  assign bus.active = active_q;
  assign bus.warn   = warn_q;
endmodule

// File: tb/tb_multi_lamp_ctrl.sv
// Directed and random checks of multi_lamp_ctrl against an age-based reference model.
module tb_multi_lamp_ctrl;
  localparam int N_CH = 2;
  localparam int N_SW = 3;
  localparam int HOLD = 16;
  localparam int WARN = 4;
  localparam int BS   = 0;
`ifdef LAMP_WARN_BLINK_EN
  localparam int LAMP_HI = 14;
`else
  localparam int LAMP_HI = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_lamp_ctrl_if #(.N_CH(N_CH), .N_SW(N_SW)) bus ();

  multi_lamp_ctrl #(
    .N_CH(N_CH), .N_SW(N_SW), .HOLD_CYCLES(HOLD), .WARN_CYCLES(WARN), .BLINK_SHIFT(BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // age = edges since the last accepted trigger; HOLD means idle
  int age [N_CH];
  logic [N_CH*N_SW-1:0] hist [3];
  logic [N_CH-1:0] exp_lamp, exp_active, exp_warn;

  function automatic bit grp_par(input logic [N_CH*N_SW-1:0] v, input int c);
    return ^v[c*N_SW +: N_SW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) age[c] = HOLD;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    exp_lamp = '0; exp_active = '0; exp_warn = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < N_CH; c++) begin
      int a;
      int remaining;
      bit blink;
      bit t;
      a = age[c];
      remaining = HOLD - 1 - a;
`ifdef LAMP_WARN_BLINK_EN
      blink = ((remaining >> BS) & 1) != 0;
`else
      blink = 1'b1;
`endif
      exp_active[c] = (a < HOLD);
      exp_warn[c]   = (a >= HOLD - WARN) && (a < HOLD);
      if (bus.force_off[c])     exp_lamp[c] = 1'b0;
      else if (bus.force_on[c]) exp_lamp[c] = 1'b1;
      else if (a < HOLD - WARN) exp_lamp[c] = 1'b1;
      else if (a < HOLD)        exp_lamp[c] = blink;
      else                      exp_lamp[c] = 1'b0;
      t = grp_par(hist[1], c) ^ grp_par(hist[2], c);
      if (bus.force_off[c]) age[c] = HOLD;
      else if (t)           age[c] = 0;
      else if (a < HOLD)    age[c] = a + 1;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = bus.sw;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("lamp", bus.lamp, exp_lamp);
    check("active", bus.active, exp_active);
    check("warn", bus.warn, exp_warn);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 60 && (age[0] < HOLD || age[1] < HOLD); k++) step();
    step();
    check(tag, bus.active, 0);
  endtask

  task automatic measure_rise(input string tag, input int c);
    int first = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus.lamp[c] && first < 0) first = k;
    end
    check(tag, first, 4);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, na, nw, nl, found, k;
    rst = 1'b1;
    bus.sw = '0;
    bus.force_on = '0;
    bus.force_off = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_lamp", bus.lamp, 0);
    check("rst_active", bus.active, 0);
    check("rst_warn", bus.warn, 0);
    rst = 1'b0;
    repeat (3) step();

    // single toggle: latency, hold length, warn window, blink
    bus.sw[0] = ~bus.sw[0];
    first = -1; na = 0; nw = 0; nl = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (bus.lamp[0] && first < 0) first = i;
      na += int'(bus.active[0]);
      nw += int'(bus.warn[0]);
      nl += int'(bus.lamp[0]);
      check("s1_lamp1", bus.lamp[1], 0);
    end
    check("s1_rise", first, 4);
    check("s1_active_len", na, HOLD);
    check("s1_warn_len", nw, WARN);
    check("s1_lamp_len", nl, LAMP_HI);

    // retrigger mid-hold and exactly at tmr==0
    wait_idle("s2_idle0");
    bus.sw[1] = ~bus.sw[1];
    repeat (13) step();
    bus.sw[1] = ~bus.sw[1];
    repeat (4) step();
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (age[0] == 13) found = 1;
      else step();
    end
    check("s2_wait", found, 1);
    bus.sw[1] = ~bus.sw[1];
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      step();
      if (!bus.active[0]) k = i;
    end
    check("s2_off_after", k, 20);

    // simultaneous pair cancels; other channel independent
    wait_idle("s3_idle");
    bus.sw[0] = ~bus.sw[0];
    bus.sw[2] = ~bus.sw[2];
    repeat (8) step();
    check("s3_pair_cancel", bus.active[0], 0);
    bus.sw[3] = ~bus.sw[3];
    repeat (4) step();
    check("s3_ch1_only", bus.active, 2'b10);

    // force_off mid-hold with a toggle hidden under it, then force_on while idle
    wait_idle("s4_idle");
    bus.sw[0] = ~bus.sw[0];
    repeat (6) step();
    bus.force_off[0] = 1'b1;
    bus.sw[1] = ~bus.sw[1];
    step();
    check("s4_fo_lamp", bus.lamp[0], 0);
    repeat (2) step();
    bus.force_off[0] = 1'b0;
    repeat (10) step();
    check("s4_no_retrig", bus.active[0], 0);
    bus.force_on[1] = 1'b1;
    step();
    check("s4_fon_lamp", bus.lamp[1], 1);
    check("s4_fon_active", bus.active[1], 0);
    bus.force_on[1] = 1'b0;
    step();

    // asynchronous reset mid-hold
    bus.sw[4] = ~bus.sw[4];
    repeat (7) step();
    #3;
    rst = 1'b1;
    #1;
    check("s5_rst_lamp", bus.lamp, 0);
    check("s5_rst_active", bus.active, 0);
    check("s5_rst_warn", bus.warn, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_idle("s5_idle");
    bus.sw[0] = ~bus.sw[0];
    measure_rise("s5_rise", 0);

    // random toggles and forces
    wait_idle("rnd_idle0");
    for (int i = 0; i < 300; i++) begin
      int idx;
      if ($urandom_range(5) == 0) begin
        idx = $urandom_range(N_CH*N_SW-1);
        bus.sw[idx] = ~bus.sw[idx];
      end
      if ($urandom_range(9) == 0) begin
        idx = $urandom_range(N_CH*N_SW-1);
        bus.sw[idx] = ~bus.sw[idx];
      end
      bus.force_off = ($urandom_range(19) == 0) ? N_CH'($urandom_range(3)) : '0;
      bus.force_on  = ($urandom_range(11) == 0) ? N_CH'($urandom_range(3)) : '0;
      step();
    end
    bus.force_off = '0;
    bus.force_on  = '0;
    wait_idle("rnd_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
